// File: rtl/ysyx_23060208_isram.sv
// ---------------------------------------------------------------------------
// ysyx_23060208_isram -- instruction-SRAM read responder (AR + R slave).
//
// Accepts one read address at a time from the IFU. It returns one 32-bit word
// after LATENCY cycles. When RAND_LAT=1, an extra 0..3 cycles taken from an
// LFSR are added. The R response is held stable until the initiator takes it.
//
// Handshake semantics: a beat transfers on a rising edge where valid and
// ready are both high. The responder never drops rvalid without an R
// handshake, and it never raises arready while a request is outstanding.
// rready may be high before rvalid; that has no effect.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   isram_araddr       read address (sampled only at the AR handshake)
//   isram_arvalid/ready  read-address handshake
//   isram_rdata        read data (0 on error responses)
//   isram_rresp        2'b00 OKAY, 2'b10 SLVERR (misaligned), 2'b11 DECERR
//   isram_rvalid/ready   read-data handshake
//   dbg_state          FSM state (0 IDLE, 1 DELAY, 2 RESP)
//   dbg_pmem_reads     number of backing-store reads issued since reset
// ---------------------------------------------------------------------------
module ysyx_23060208_isram #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    LATENCY    = 1,
  parameter int                    RAND_LAT   = 0,
  parameter logic [DATA_WIDTH-1:0] MEM_BASE   = 'h8000_0000,
  parameter logic [DATA_WIDTH-1:0] MEM_SIZE   = 'h0800_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] isram_araddr,
  input  logic                  isram_arvalid,
  output logic                  isram_arready,
  output logic [DATA_WIDTH-1:0] isram_rdata,
  output logic                  isram_rvalid,
  output logic [1:0]            isram_rresp,
  input  logic                  isram_rready,
  output logic [1:0]            dbg_state,
  output logic [31:0]           dbg_pmem_reads
);

  localparam int CW = 5;  // holds up to 14 + 3

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         cnt;
  logic [7:0]            lfsr;
  logic                  lfsr_fb;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [CW-1:0]         load_val;
  logic                  ar_hs;
  logic                  capture;
  logic [DATA_WIDTH-1:0] cap_addr;
  logic [1:0]            cap_resp;
  logic [DATA_WIDTH:0]   cap_addr_x;
  logic [DATA_WIDTH:0]   win_lo;
  logic [DATA_WIDTH:0]   win_hi;
  logic [31:0]           rd_cnt;

  // Simulation memory image. The word at byte offset o from MEM_BASE is
  // 0x0000_0413 ^ (o * 0x9E37_79B9). So the reset vector holds 0x0000_0413
  // (addi s0,zero,0), and the other words are distinct.
  function automatic logic [DATA_WIDTH-1:0] pmem_read(input logic [DATA_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] off;
    off = addr - MEM_BASE;
    return DATA_WIDTH'(32'h0000_0413) ^ (off * DATA_WIDTH'(32'h9E37_79B9));
  endfunction

  // Fibonacci LFSR, taps 8,6,5,4.
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  assign ar_hs    = isram_arvalid && (state == IDLE);
  assign load_val = CW'(LATENCY - 1) + ((RAND_LAT != 0) ? {3'b000, lfsr[1:0]} : '0);

  // The response is registered on the edge that enters RESP. With a zero
  // load, that edge is the AR handshake edge, so the live address is used.
  // A nonzero load captures the response when the counter runs out.
  assign capture  = (ar_hs && (load_val == '0)) ||
                    ((state == DELAY) && (cnt <= CW'(1)));
  assign cap_addr = (state == IDLE) ? isram_araddr : addr_q;

  // The window check is 33 bits wide, so MEM_BASE + MEM_SIZE cannot wrap.
  assign cap_addr_x = {1'b0, cap_addr};
  assign win_lo     = {1'b0, MEM_BASE};
  assign win_hi     = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

  always_comb begin
    cap_resp = RESP_OKAY;
    if (cap_addr_x < win_lo || cap_addr_x >= win_hi) cap_resp = RESP_DECERR;
    else if (cap_addr[1:0] != 2'b00)                  cap_resp = RESP_SLVERR;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ar_hs) state_nx = (load_val == '0) ? RESP : DELAY;
      DELAY:   if (cnt <= CW'(1)) state_nx = RESP;
      RESP:    if (isram_rready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    isram_arready = 1'b0;
    isram_rvalid  = 1'b0;
    case (state)
      IDLE:    isram_arready = 1'b1;
      RESP:    isram_rvalid  = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latched address, delay counter, LFSR, response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      lfsr        <= 8'hA5;
      addr_q      <= '0;
      isram_rdata <= '0;
      isram_rresp <= RESP_OKAY;
      rd_cnt      <= '0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_fb};
      if (ar_hs) begin
        addr_q <= isram_araddr;
        cnt    <= load_val;
      end else if (state == DELAY) begin
        cnt <= cnt - CW'(1);
      end
      if (capture) begin
        isram_rresp <= cap_resp;
        if (cap_resp == RESP_OKAY) begin
          isram_rdata <= pmem_read(cap_addr & ~DATA_WIDTH'(3));
          rd_cnt      <= rd_cnt + 32'd1;
        end else begin
          isram_rdata <= '0;
        end
      end
    end
  end

  assign dbg_state      = state;
  assign dbg_pmem_reads = rd_cnt;

endmodule

// File: tb/tb_ysyx_23060208_isram.sv
// Directed bench for ysyx_23060208_isram. There are four instances:
//   0: LATENCY=1, 1: LATENCY=4, 2: LATENCY=8, 3: LATENCY=1 with RAND_LAT=1.
module tb_ysyx_23060208_isram;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [N];
  logic [31:0] araddr  [N];
  logic        arvalid [N];
  logic        rready  [N];
  wire         arready [N];
  wire         rvalid  [N];
  wire  [31:0] rdata   [N];
  wire  [1:0]  rresp   [N];
  wire  [1:0]  dstate  [N];
  wire  [31:0] pmem_cnt[N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    ysyx_23060208_isram #(
      .LATENCY  ((g == 1) ? 4 : (g == 2) ? 8 : 1),
      .RAND_LAT ((g == 3) ? 1 : 0)
    ) dut (
      .clk            (clk),
      .rst            (rst[g]),
      .isram_araddr   (araddr[g]),
      .isram_arvalid  (arvalid[g]),
      .isram_arready  (arready[g]),
      .isram_rdata    (rdata[g]),
      .isram_rvalid   (rvalid[g]),
      .isram_rresp    (rresp[g]),
      .isram_rready   (rready[g]),
      .dbg_state      (dstate[g]),
      .dbg_pmem_reads (pmem_cnt[g])
    );
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory image: the word at offset o is 0x413 ^ (o * 0x9E3779B9).
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] off;
    off = (addr & ~32'd3) - 32'h8000_0000;
    return 32'h0000_0413 ^ (off * 32'h9E37_79B9);
  endfunction

  // ---------------- driver ----------------
  // Issues one read with rready already high. The task measures the cycles
  // from the AR handshake cycle to the first rvalid cycle. It drives
  // addr_after on araddr once the handshake is done.
  task automatic do_read(input int i, input logic [31:0] addr, input logic [31:0] addr_after,
                         output int lat, output logic [31:0] data, output logic [1:0] resp);
    int n;
    lat = 0; data = '0; resp = '0;
    @(negedge clk);
    araddr[i] = addr; arvalid[i] = 1'b1;
    check($sformatf("inst%0d arready idle", i), arready[i], 1);
    n = 0;
    while (!arready[i] && n < 20) begin @(negedge clk); n++; end
    if (!arready[i]) begin
      check($sformatf("inst%0d ar timeout", i), 0, 1);
      arvalid[i] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    arvalid[i] = 1'b0; araddr[i] = addr_after;
    lat = 1;
    while (!rvalid[i] && lat < 40) begin @(negedge clk); lat++; end
    if (!rvalid[i]) begin
      check($sformatf("inst%0d r timeout", i), 0, 1);
      return;
    end
    data = rdata[i]; resp = rresp[i];
    @(negedge clk);
    check($sformatf("inst%0d arready after r", i), arready[i], 1);
    check($sformatf("inst%0d rvalid drop", i), rvalid[i], 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int          inst;
    logic [31:0] addr;
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int          lat;
    logic [31:0] data;
    logic [1:0]  resp;
    logic [31:0] c0;
    logic [31:0] held;
    logic        seen;

    vecs[0] = '{0, 32'h8000_0000, 2'b00, 32'h0000_0413,             1};
    vecs[1] = '{0, 32'h8000_0004, 2'b00, mem_word(32'h8000_0004), 1};
    vecs[2] = '{0, 32'h87FF_FFFC, 2'b00, mem_word(32'h87FF_FFFC), 1};
    vecs[3] = '{0, 32'h8800_0000, 2'b11, 32'h0,                    1};
    vecs[4] = '{0, 32'h7FFF_FFFC, 2'b11, 32'h0,                    1};
    vecs[5] = '{0, 32'h8000_0002, 2'b10, 32'h0,                    1};
    vecs[6] = '{0, 32'hFFFF_FFFC, 2'b11, 32'h0,                    1};
    vecs[7] = '{1, 32'h8000_0010, 2'b00, mem_word(32'h8000_0010), 4};
    vecs[8] = '{1, 32'h8000_0001, 2'b10, 32'h0,                    4};

    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; arvalid[i] = 1'b0; rready[i] = 1'b0; araddr[i] = '0;
    end
    #12;
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset%0d arready", i), arready[i], 1);
      check($sformatf("reset%0d rvalid", i), rvalid[i], 0);
      check($sformatf("reset%0d rdata", i), rdata[i], 0);
      check($sformatf("reset%0d rresp", i), rresp[i], 0);
      check($sformatf("reset%0d pmem reads", i), pmem_cnt[i], 0);
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) rst[i] = 1'b0;
    for (int i = 0; i < N; i++) rready[i] = 1'b1;

    // Table: data, response, latency and the count of backing-store reads
    for (int v = 0; v < 9; v++) begin
      c0 = pmem_cnt[vecs[v].inst];
      do_read(vecs[v].inst, vecs[v].addr, vecs[v].addr, lat, data, resp);
      check($sformatf("vec%0d rresp", v), resp, vecs[v].resp);
      check($sformatf("vec%0d rdata", v), data, vecs[v].data);
      check($sformatf("vec%0d latency", v), lat, vecs[v].lat);
      check($sformatf("vec%0d pmem reads", v), pmem_cnt[vecs[v].inst],
            c0 + ((vecs[v].resp == 2'b00) ? 32'd1 : 32'd0));
    end

    // Backpressure: R held for 5 cycles, and a second AR is refused meanwhile
    rready[0] = 1'b0;
    @(negedge clk);
    araddr[0] = 32'h8000_0020; arvalid[0] = 1'b1;
    check("bp arready idle", arready[0], 1);
    @(posedge clk);
    @(negedge clk);
    araddr[0] = 32'h8000_0080;
    check("bp rvalid rise", rvalid[0], 1);
    c0 = pmem_cnt[0];
    held = mem_word(32'h8000_0020);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d rvalid", k), rvalid[0], 1);
      check($sformatf("bp%0d rdata", k), rdata[0], held);
      check($sformatf("bp%0d rresp", k), rresp[0], 0);
      check($sformatf("bp%0d arready", k), arready[0], 0);
      @(negedge clk);
    end
    rready[0] = 1'b1; arvalid[0] = 1'b0;
    @(negedge clk);
    check("bp rvalid after hs", rvalid[0], 0);
    check("bp arready after hs", arready[0], 1);
    check("bp no extra read", pmem_cnt[0], c0);
    @(negedge clk);
    check("bp no phantom r", rvalid[0], 0);

    // LATENCY=4: araddr changes after the handshake
    do_read(1, 32'h8000_0040, 32'h8000_0100, lat, data, resp);
    check("lat4 rdata", data, mem_word(32'h8000_0040));
    check("lat4 rresp", resp, 0);
    check("lat4 latency", lat, 4);

    // Asynchronous reset in the middle of DELAY
    @(negedge clk);
    araddr[2] = 32'h8000_0008; arvalid[2] = 1'b1;
    check("arst arready idle", arready[2], 1);
    @(posedge clk);
    @(negedge clk);
    arvalid[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("arst in delay arready", arready[2], 0);
    check("arst in delay rvalid", rvalid[2], 0);
    #1 rst[2] = 1'b1;
    #1;
    check("arst rvalid", rvalid[2], 0);
    check("arst arready", arready[2], 1);
    @(negedge clk);
    rst[2] = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (rvalid[2]) seen = 1'b1;
    end
    check("arst no response", seen, 0);
    check("arst pmem reads", pmem_cnt[2], 0);

    // Randomised latency: 200 sequential fetches
    c0 = pmem_cnt[3];
    for (int k = 0; k < 200; k++) begin
      logic [31:0] a;
      a = 32'h8000_0000 + 32'(4 * k);
      do_read(3, a, a, lat, data, resp);
      check($sformatf("rand%0d rdata", k), data, mem_word(a));
      check($sformatf("rand%0d rresp", k), resp, 0);
      check($sformatf("rand%0d latency in 1..4", k), (lat >= 1 && lat <= 4), 1);
    end
    check("rand pmem reads", pmem_cnt[3], c0 + 32'd200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
